// File: rtl/cpu_ta_burst_ctrl.sv
// MC68040 transfer-acknowledge sequencer for the PCI bridge.
// Issues one TA per beat only when the bridge FIFO can accept or supply data,
// times out each beat with TEA, then holds the pads driven high for one
// recovery cycle before releasing them.
module cpu_ta_burst_ctrl #(
    parameter int unsigned BURST_BEATS = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned REG_WAIT    = 2
) (
    input  logic                           BCLK,
    input  logic                           RESET,
    input  logic                           nTS,
    input  logic [1:0]                     TT,
    input  logic                           RnW,
    input  logic                           SEL,
    input  logic                           REGSEL,
    input  logic                           nBG,
    input  logic                           WR_READY,
    input  logic                           RD_VALID,
    output logic                           nTA,
    output logic                           nTEA,
    output logic                           TA_OE,
    output logic                           WR_PUSH,
    output logic                           RD_POP,
    output logic [$clog2(BURST_BEATS)-1:0] BEAT,
    output logic                           BUSY
);

    localparam int unsigned BW = $clog2(BURST_BEATS);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    // Wait counter must also be able to hold REG_WAIT (up to 15).
    localparam int unsigned WW = (TW > 4) ? TW : 4;

    localparam logic [WW-1:0] TimeoutW  = WW'(TIMEOUT);
    localparam logic [WW-1:0] RegWaitW  = WW'(REG_WAIT);
    localparam logic [BW-1:0] LastBurst = BW'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StRecover
    } state_e;

    state_e        state_q, state_d;
    logic          rnw_q, rnw_d;
    logic          regsel_q, regsel_d;
    logic [BW-1:0] last_q, last_d;   // index of the final beat of this transfer
    logic [BW-1:0] cnt_q, cnt_d;     // beat currently waiting for readiness
    logic [WW-1:0] wait_q, wait_d;
    logic          nta_q, nta_d;
    logic          ntea_q, ntea_d;
    logic          ta_oe_q, ta_oe_d;
    logic          push_q, push_d;
    logic          pop_q, pop_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          busy_q, busy_d;
    logic          ready;

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        regsel_d = regsel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        beat_d   = beat_q;
        nta_d    = 1'b1;
        ntea_d   = 1'b1;
        ta_oe_d  = 1'b0;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!nTS && SEL && !nBG) begin
                    state_d  = StData;
                    rnw_d    = RnW;
                    regsel_d = REGSEL;
                    // Register accesses are always single-beat, even with TT=01.
                    last_d   = (TT == 2'b01 && !REGSEL) ? LastBurst : '0;
                    cnt_d    = '0;
                    wait_d   = '0;
                    beat_d   = '0;
                    ta_oe_d  = 1'b1;
                end
            end
            StData: begin
                ta_oe_d = 1'b1;
                ready   = regsel_q ? (wait_q == RegWaitW) : (rnw_q ? RD_VALID : WR_READY);
                if (ready) begin
                    nta_d  = 1'b0;
                    push_d = !rnw_q && !regsel_q;
                    pop_d  = rnw_q && !regsel_q;
                    beat_d = cnt_q;
                    if (cnt_q == last_q) begin
                        state_d = StRecover;
                    end else begin
                        cnt_d  = cnt_q + BW'(1);
                        wait_d = '0;
                    end
                end else if (wait_q == TimeoutW) begin
                    // Abandon the remaining beats; counter stays saturated.
                    ntea_d  = 1'b0;
                    state_d = StRecover;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            StRecover: begin
                // Pads stay driven high for one more cycle after the final TA/TEA.
                ta_oe_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers, cleared asynchronously by RESET
    always_ff @(posedge BCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            rnw_q    <= 1'b0;
            regsel_q <= 1'b0;
            last_q   <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            nta_q    <= 1'b1;
            ntea_q   <= 1'b1;
            ta_oe_q  <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnw_q    <= rnw_d;
            regsel_q <= regsel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            nta_q    <= nta_d;
            ntea_q   <= ntea_d;
            ta_oe_q  <= ta_oe_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
        end
    end

    assign nTA     = nta_q;
    assign nTEA    = ntea_q;
    assign TA_OE   = ta_oe_q;
    assign WR_PUSH = push_q;
    assign RD_POP  = pop_q;
    assign BEAT    = beat_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_cpu_ta_burst_ctrl.sv
// Self-checking bench for cpu_ta_burst_ctrl. A transaction-level predictor
// walks each beat's wait window over the readiness schedule to produce the
// expected per-cycle pad and strobe values.
module tb_cpu_ta_burst_ctrl;

    localparam int BEATS = 4;
    localparam int TMO   = 8;
    localparam int RW    = 2;
    localparam int MAXC  = 64;
    // Idle vector, bit order {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY}
    localparam logic [5:0] IdleVec = 6'b110000;

    logic       BCLK, RESET, nTS, RnW, SEL, REGSEL, nBG, WR_READY, RD_VALID;
    logic [1:0] TT;
    logic       nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY;
    logic [1:0] BEAT;

    int n_checks = 0;
    int n_pass   = 0;

    bit         sched_wr [MAXC];
    bit         sched_rd [MAXC];
    logic [5:0] exp_vec  [MAXC];
    int         exp_beat [MAXC];
    logic [5:0] obs_vec  [MAXC];
    logic [1:0] obs_beat [MAXC];

    cpu_ta_burst_ctrl #(
        .BURST_BEATS(BEATS),
        .TIMEOUT    (TMO),
        .REG_WAIT   (RW)
    ) dut (
        .BCLK    (BCLK),
        .RESET   (RESET),
        .nTS     (nTS),
        .TT      (TT),
        .RnW     (RnW),
        .SEL     (SEL),
        .REGSEL  (REGSEL),
        .nBG     (nBG),
        .WR_READY(WR_READY),
        .RD_VALID(RD_VALID),
        .nTA     (nTA),
        .nTEA    (nTEA),
        .TA_OE   (TA_OE),
        .WR_PUSH (WR_PUSH),
        .RD_POP  (RD_POP),
        .BEAT    (BEAT),
        .BUSY    (BUSY)
    );

    initial BCLK = 1'b0;
    always #5 BCLK = ~BCLK;

    task automatic fill_sched(input int pw, input int pr);
        for (int i = 0; i < MAXC; i++) begin
            sched_wr[i] = (int'($urandom_range(0, 99)) < pw);
            sched_rd[i] = (int'($urandom_range(0, 99)) < pr);
        end
    endtask

    // Each beat gets a window of TMO+1 wait cycles; the first ready cycle in the
    // window yields a TA one cycle later, otherwise TEA ends the transfer.
    task automatic model_txn(input bit rnw, input bit burst, input bit regsel, output int e);
        int  nb, t, c;
        bit  found, rdy;
        for (int i = 0; i < MAXC; i++) begin
            exp_vec[i]  = IdleVec;
            exp_beat[i] = -1;
        end
        nb = (burst && !regsel) ? BEATS : 1;
        t  = 1;
        e  = 0;
        for (int b = 0; b < nb; b++) begin
            found = 1'b0;
            for (int k = 0; k <= TMO && !found; k++) begin
                rdy = regsel ? (k == RW) : (rnw ? sched_rd[t + k] : sched_wr[t + k]);
                if (rdy) begin
                    c             = t + k + 1;
                    exp_vec[c][5] = 1'b0;
                    exp_vec[c][2] = !rnw && !regsel;
                    exp_vec[c][1] = rnw && !regsel;
                    exp_beat[c]   = b;
                    t             = c;
                    e             = c;
                    found         = 1'b1;
                end
            end
            if (!found) begin
                e             = t + TMO + 1;
                exp_vec[e][4] = 1'b0;
                break;
            end
        end
        for (int i = 1; i <= e + 1; i++) exp_vec[i][3] = 1'b1;
        for (int i = 1; i <= e; i++) exp_vec[i][0] = 1'b1;
    endtask

    // Drives one transfer starting in cycle 0 and records outputs per cycle.
    // Control inputs are scrambled while the DUT is busy; they must be ignored.
    task automatic run_txn(input bit rnw, input logic [1:0] tt, input bit regsel,
                           input int ncyc, input int busy_until);
        @(posedge BCLK);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                nTS = 1'b0; RnW = rnw; TT = tt; REGSEL = regsel; SEL = 1'b1; nBG = 1'b0;
            end else if (c <= busy_until) begin
                nTS = 1'($urandom); RnW = 1'($urandom); TT = 2'($urandom);
                REGSEL = 1'($urandom); SEL = 1'($urandom); nBG = 1'($urandom);
            end else begin
                nTS = 1'b1;
            end
            WR_READY = sched_wr[c];
            RD_VALID = sched_rd[c];
            @(negedge BCLK);
            obs_vec[c]  = {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY};
            obs_beat[c] = BEAT;
            @(posedge BCLK);
            #1;
        end
        nTS = 1'b1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (2) @(posedge BCLK);
        @(negedge BCLK);
        n_checks++;
        if ({nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY} !== IdleVec || BEAT !== 2'd0)
            $display("FAIL reset_values: got %b beat %0d want %b beat 0",
                     {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY}, BEAT, IdleVec);
        else n_pass++;
        #2 RESET = 1'b0;
        @(negedge BCLK);
        n_checks++;
        if ({nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY} !== IdleVec)
            $display("FAIL reset_release: got %b want %b",
                     {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY}, IdleVec);
        else n_pass++;
    endtask

    task automatic test_write_single;
        int e;
        fill_sched(100, 50);
        model_txn(1'b0, 1'b0, 1'b0, e);
        run_txn(1'b0, 2'b00, 1'b0, e + 3, e);
        for (int c = 0; c < e + 3; c++) begin
            n_checks++;
            if (obs_vec[c] !== exp_vec[c])
                $display("FAIL wr_single cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            else n_pass++;
        end
    endtask

    task automatic test_read_burst;
        int e;
        for (int s = 0; s < 2; s++) begin
            fill_sched(50, 100);
            // Second pass: FIFO runs dry for cycles 2..5.
            if (s == 1) for (int i = 2; i <= 5; i++) sched_rd[i] = 1'b0;
            model_txn(1'b1, 1'b1, 1'b0, e);
            run_txn(1'b1, 2'b01, 1'b0, e + 3, e);
            for (int c = 0; c < e + 3; c++) begin
                n_checks++;
                if (obs_vec[c] !== exp_vec[c])
                    $display("FAIL rd_burst%0d cyc %0d: got %b want %b", s, c, obs_vec[c],
                             exp_vec[c]);
                else n_pass++;
                if (exp_beat[c] >= 0) begin
                    n_checks++;
                    if (obs_beat[c] !== 2'(exp_beat[c]))
                        $display("FAIL rd_burst%0d_beat cyc %0d: got %0d want %0d", s, c,
                                 obs_beat[c], exp_beat[c]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_timeout;
        int e;
        fill_sched(0, 100);
        model_txn(1'b0, 1'b0, 1'b0, e);
        run_txn(1'b0, 2'b00, 1'b0, e + 3, e);
        for (int c = 0; c < e + 3; c++) begin
            n_checks++;
            if (obs_vec[c] !== exp_vec[c])
                $display("FAIL timeout cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            else n_pass++;
        end
        n_checks++;
        if (obs_vec[10][4] !== 1'b0)
            $display("FAIL timeout_tea_cycle10: got nTEA=%b want 0", obs_vec[10][4]);
        else n_pass++;
    endtask

    task automatic test_regsel;
        int e;
        fill_sched(100, 100);
        model_txn(1'b1, 1'b1, 1'b1, e);
        run_txn(1'b1, 2'b01, 1'b1, e + 3, e);
        for (int c = 0; c < e + 3; c++) begin
            n_checks++;
            if (obs_vec[c] !== exp_vec[c])
                $display("FAIL regsel cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst;
        int e;
        @(posedge BCLK);
        #1;
        nTS = 1'b0; SEL = 1'b1; nBG = 1'b0; TT = 2'b01; RnW = 1'b1; REGSEL = 1'b0;
        RD_VALID = 1'b1; WR_READY = 1'b1;
        @(posedge BCLK);
        #1 nTS = 1'b1;
        repeat (3) @(posedge BCLK);
        #3;
        n_checks++;
        if (nTA !== 1'b0 || RD_POP !== 1'b1 || BEAT !== 2'd2)
            $display("FAIL pre_reset_beat2: got nTA=%b pop=%b beat=%0d want 0 1 2",
                     nTA, RD_POP, BEAT);
        else n_pass++;
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY} !== IdleVec || BEAT !== 2'd0)
            $display("FAIL async_reset: got %b beat %0d want %b beat 0",
                     {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY}, BEAT, IdleVec);
        else n_pass++;
        #2 RESET = 1'b0;
        repeat (2) begin
            @(negedge BCLK);
            n_checks++;
            if ({nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY} !== IdleVec)
                $display("FAIL post_reset_idle: got %b want %b",
                         {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY}, IdleVec);
            else n_pass++;
        end
        fill_sched(50, 100);
        model_txn(1'b1, 1'b1, 1'b0, e);
        run_txn(1'b1, 2'b01, 1'b0, e + 3, e);
        for (int c = 0; c < e + 3; c++) begin
            n_checks++;
            if (obs_vec[c] !== exp_vec[c] ||
                (exp_beat[c] >= 0 && obs_beat[c] !== 2'(exp_beat[c])))
                $display("FAIL after_reset cyc %0d: got %b beat %0d want %b beat %0d", c,
                         obs_vec[c], obs_beat[c], exp_vec[c], exp_beat[c]);
            else n_pass++;
        end
    endtask

    task automatic test_no_start;
        for (int s = 0; s < 2; s++) begin
            @(posedge BCLK);
            #1;
            nTS = 1'b0; TT = 2'b01; RnW = 1'b0; REGSEL = 1'b0;
            WR_READY = 1'b1; RD_VALID = 1'b1;
            SEL = (s == 0) ? 1'b1 : 1'b0;
            nBG = (s == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge BCLK);
                n_checks++;
                if ({nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY} !== IdleVec)
                    $display("FAIL no_start%0d cyc %0d: got %b want %b", s, c,
                             {nTA, nTEA, TA_OE, WR_PUSH, RD_POP, BUSY}, IdleVec);
                else n_pass++;
            end
            nTS = 1'b1; SEL = 1'b1; nBG = 1'b0;
        end
    endtask

    task automatic test_random;
        int         e, p;
        bit         rnw, regsel;
        logic [1:0] tt;
        for (int i = 0; i < 30; i++) begin
            rnw    = 1'($urandom);
            tt     = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom);
            regsel = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 15;
                2:       p = 50;
                default: p = 100;
            endcase
            fill_sched(p, p);
            model_txn(rnw, tt == 2'b01, regsel, e);
            run_txn(rnw, tt, regsel, e + 3, e);
            for (int c = 0; c < e + 3; c++) begin
                n_checks++;
                if (obs_vec[c] !== exp_vec[c] ||
                    (exp_beat[c] >= 0 && obs_beat[c] !== 2'(exp_beat[c])))
                    $display("FAIL random txn %0d cyc %0d: got %b beat %0d want %b beat %0d",
                             i, c, obs_vec[c], obs_beat[c], exp_vec[c], exp_beat[c]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        RESET = 1'b1; nTS = 1'b1; TT = 2'b00; RnW = 1'b0; SEL = 1'b0; REGSEL = 1'b0;
        nBG = 1'b1; WR_READY = 1'b0; RD_VALID = 1'b0;
        test_reset();
        test_write_single();
        test_read_burst();
        test_timeout();
        test_regsel();
        test_reset_mid_burst();
        test_no_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
